// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared state encoding and sizing helper for the serial adder
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bit width needed to count 0..value-1; never narrower than one bit.
  function automatic int clog2(input int value);
    int w;
    w = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) w = i + 1;
    end
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/fa_1bit.sv
// rtl/fa_1bit.sv - one-bit full adder cell driven by propagate/generate terms
module fa_1bit (
  input  logic p,
  input  logic g,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = p ^ ci;
  assign co = g | (p & ci);

endmodule

// File: rtl/serial_adder_seq.sv
// rtl/serial_adder_seq.sv - bit-serial adder, one operand bit per clock, LSB first
// Optional subtract mode is compiled in with SERIAL_ADDER_SUB_EN.
module serial_adder_seq
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             C,
  input  logic             R,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int CW = clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic [WIDTH-1:0] b_eff;
  logic             c_eff;
  logic             p_bit;
  logic             g_bit;
  logic             s_bit;
  logic             co_bit;
  logic [WIDTH-1:0] s_msb;

`ifdef SERIAL_ADDER_SUB_EN
  // a - b is formed as a + ~b + 1, so cin has no meaning in subtract mode.
  assign b_eff = sub ? ~b : b;
  assign c_eff = sub ? 1'b1 : cin;
`else
  logic unused_sub;
  assign unused_sub = sub;
  assign b_eff      = b;
  assign c_eff      = cin;
`endif

  assign p_bit = a_sh[0] ^ b_sh[0];
  assign g_bit = a_sh[0] & b_sh[0];
  assign s_msb = WIDTH'(s_bit) << (WIDTH - 1);

  fa_1bit u_fa (
    .p  (p_bit),
    .g  (g_bit),
    .ci (carry),
    .s  (s_bit),
    .co (co_bit)
  );

  always_ff @(posedge C or posedge R) begin
    if (R) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      a_sh      <= '0;
      b_sh      <= '0;
      res       <= '0;
      carry     <= 1'b0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_sh     <= a;
            b_sh     <= b_eff;
            carry    <= c_eff;
            cnt      <= '0;
            state    <= RUN;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        RUN: begin
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          res   <= (res >> 1) | s_msb;
          carry <= co_bit;
          cnt   <= cnt + CW'(1);
          if (cnt == LAST) begin
            state     <= DONE;
            busy      <= 1'b0;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          // Result stays in res/carry until the consumer takes it.
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  assign sum  = res;
  assign cout = carry;

endmodule

// File: tb/tb_serial_adder_seq.sv
// tb/tb_serial_adder_seq.sv - directed self-checking bench for serial_adder_seq
// Expected subtract results follow SERIAL_ADDER_SUB_EN when it is defined.
module tb_serial_adder_seq;

  logic       C, R;
  logic       in_valid, in_ready, out_valid, out_ready, busy;
  logic [7:0] a, b, sum;
  logic       cin, sub, cout;

  logic       in_valid1, in_ready1, out_valid1, busy1;
  logic [0:0] a1, b1, sum1;
  logic       cin1, cout1;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  serial_adder_seq #(.WIDTH(8)) dut (
    .C(C), .R(R), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .busy(busy)
  );

  serial_adder_seq #(.WIDTH(1)) dut1 (
    .C(C), .R(R), .in_valid(in_valid1), .in_ready(in_ready1), .a(a1), .b(b1),
    .cin(cin1), .sub(1'b0), .out_valid(out_valid1), .out_ready(1'b1),
    .sum(sum1), .cout(cout1), .busy(busy1)
  );

  initial begin
    C = 1'b0;
    forever #5 C = ~C;
  end

  always @(posedge C) cyc++;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       sub;
    logic [7:0] s;
    logic       co;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_op(input string nm, input logic [7:0] ta, input logic [7:0] tb_,
                       input logic tcin, input logic tsub, input bit scramble,
                       input int hold, input logic [7:0] es, input logic eco);
    int guard, lat, nb;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(posedge C); #1; guard++;
    end
    a = ta; b = tb_; cin = tcin; sub = tsub; in_valid = 1'b1;
    @(posedge C); #1;
    in_valid = 1'b0;
    lat = 0; nb = 0;
    while (!out_valid && lat < 50) begin
      if (busy) nb++;
      if (scramble) begin
        a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom); sub = 1'($urandom);
      end
      @(posedge C); #1; lat++;
    end
    check({nm, "_latency"}, lat, 8);
    check({nm, "_busy_cycles"}, nb, 8);
    check({nm, "_sum"}, sum, es);
    check({nm, "_cout"}, cout, eco);
    for (int i = 0; i < hold; i++) begin
      @(posedge C); #1;
      check({nm, "_hold_sum"}, sum, es);
      check({nm, "_hold_cout"}, cout, eco);
      check({nm, "_hold_valid"}, out_valid, 1);
      check({nm, "_hold_in_ready"}, in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge C); #1;
    out_ready = 1'b0;
    check({nm, "_released"}, {out_valid, in_ready}, 2'b01);
  endtask

  initial begin
    int guard, acc, prev_acc, seen;
    logic [8:0] full;

    vecs[0] = '{8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0};
    vecs[1] = '{8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1};
    vecs[2] = '{8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0};
    vecs[3] = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1};
    vecs[4] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0};
    vecs[5] = '{8'hAA, 8'h55, 1'b1, 1'b0, 8'h00, 1'b1};
    vecs[7] = '{8'h0F, 8'hF0, 1'b1, 1'b0, 8'h00, 1'b1};
    vecs[8] = '{8'h01, 8'hFE, 1'b0, 1'b0, 8'hFF, 1'b0};
`ifdef SERIAL_ADDER_SUB_EN
    vecs[6] = '{8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0};
    vecs[9] = '{8'h10, 8'h10, 1'b0, 1'b1, 8'h00, 1'b1};
`else
    vecs[6] = '{8'h05, 8'h07, 1'b0, 1'b1, 8'h0C, 1'b0};
    vecs[9] = '{8'h10, 8'h10, 1'b0, 1'b1, 8'h20, 1'b0};
`endif

    R = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    in_valid1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
    @(posedge C); #1;
    check("reset_outputs", {in_ready, out_valid, busy, cout}, 4'b1000);
    check("reset_sum", sum, 8'h00);
    @(posedge C); #1;
    R = 1'b0;

    // WIDTH=1 instance: a single RUN cycle, result one edge later
    a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1; in_valid1 = 1'b1;
    @(posedge C); #1;
    in_valid1 = 1'b0;
    check("w1_busy", {busy1, in_ready1, out_valid1}, 3'b100);
    @(posedge C); #1;
    check("w1_done", {out_valid1, busy1, sum1, cout1}, 4'b1011);
    @(posedge C); #1;
    a1 = 1'b1; b1 = 1'b0; cin1 = 1'b0; in_valid1 = 1'b1;
    @(posedge C); #1;
    in_valid1 = 1'b0;
    @(posedge C); #1;
    check("w1_done2", {out_valid1, sum1, cout1}, 3'b110);

    for (int i = 0; i < 10; i++)
      do_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub,
            1'b0, 0, vecs[i].s, vecs[i].co);

    do_op("hold_ff", 8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0, 5, 8'hFF, 1'b1);

    out_ready = 1'b0;
    do_op("scramble_80", 8'h80, 8'h80, 1'b0, 1'b0, 1'b1, 0, 8'h00, 1'b1);

    // Reset in the middle of RUN must abort without a result
    a = 8'h33; b = 8'h44; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(posedge C); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge C);
    #2 R = 1'b1;
    #1;
    check("midrun_reset_flags", {in_ready, out_valid, busy}, 3'b100);
    check("midrun_reset_sum", sum, 8'h00);
    @(posedge C); #1;
    R = 1'b0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge C); #1;
      if (out_valid) seen++;
    end
    check("midrun_no_result", seen, 0);
    do_op("after_reset", 8'h01, 8'h01, 1'b0, 1'b0, 1'b0, 0, 8'h02, 1'b0);

    // Back-to-back stream: in_valid and out_ready held high
    in_valid = 1'b1; out_ready = 1'b1; sub = 1'b0;
    prev_acc = 0;
    for (int i = 0; i < 100; i++) begin
      guard = 0;
      while (!in_ready && guard < 50) begin
        @(posedge C); #1; guard++;
      end
      a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
      full = {1'b0, a} + {1'b0, b} + {8'b0, cin};
      @(posedge C); #1;
      acc = cyc;
      if (i > 0) check("stream_period", acc - prev_acc, 10);
      prev_acc = acc;
      a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
      guard = 0;
      while (!out_valid && guard < 50) begin
        @(posedge C); #1; guard++;
      end
      check("stream_result", {cout, sum}, full);
    end
    in_valid = 1'b0;
    @(posedge C); #1;
    out_ready = 1'b0;
    check("stream_idle", {in_ready, out_valid, busy}, 3'b100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
